// File: rtl/sc_regmir_pkg.sv
// Shared widths, field offsets and the NOP microword for the microinstruction register pipe.
package sc_regmir_pkg;

  localparam int REG_ADDR_WIDTH_D = 6;
  localparam int ALU_WIDTH_D      = 4;
  localparam int COND_WIDTH_D     = 3;
  localparam int JMP_WIDTH_D      = 11;
  localparam int DEPTH_D          = 2;

  // Five single-bit fields: AMUX, BMUX, CMUX, RD, WR.
  function automatic int mirWidth(int regW, int aluW, int condW, int jmpW);
    return 3 * regW + aluW + condW + jmpW + 5;
  endfunction

  localparam int DATAWIDTH_BUS = mirWidth(REG_ADDR_WIDTH_D, ALU_WIDTH_D, COND_WIDTH_D, JMP_WIDTH_D);

  localparam int JMP_LSB  = 0;
  localparam int JMP_MSB  = JMP_LSB + JMP_WIDTH_D - 1;
  localparam int COND_LSB = JMP_MSB + 1;
  localparam int COND_MSB = COND_LSB + COND_WIDTH_D - 1;
  localparam int ALU_LSB  = COND_MSB + 1;
  localparam int ALU_MSB  = ALU_LSB + ALU_WIDTH_D - 1;
  localparam int WR_BIT   = ALU_MSB + 1;
  localparam int RD_BIT   = WR_BIT + 1;
  localparam int CMUX_BIT = RD_BIT + 1;
  localparam int C_LSB    = CMUX_BIT + 1;
  localparam int C_MSB    = C_LSB + REG_ADDR_WIDTH_D - 1;
  localparam int BMUX_BIT = C_MSB + 1;
  localparam int B_LSB    = BMUX_BIT + 1;
  localparam int B_MSB    = B_LSB + REG_ADDR_WIDTH_D - 1;
  localparam int AMUX_BIT = B_MSB + 1;
  localparam int A_LSB    = AMUX_BIT + 1;
  localparam int A_MSB    = A_LSB + REG_ADDR_WIDTH_D - 1;

  localparam logic [DATAWIDTH_BUS-1:0] MIR_NOP = '0;

  typedef enum logic [1:0] {
    SRC_NOP,
    SRC_HEAD,
    SRC_BYPASS
  } mirSrc_t;

endpackage

// File: rtl/sc_regmir_fifo.sv
// Circular prefetch buffer with wrapping pointers; flush and reset empty it in one cycle.
module sc_regmir_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 2
) (
  input  logic                             i_clk,
  input  logic                             i_rstN,
  input  logic                             i_flush,
  input  logic                             i_push,
  input  logic                             i_pop,
  input  logic [WIDTH-1:0]                 i_data,
  output logic [WIDTH-1:0]                 o_head,
  output logic [$clog2(DEPTH+1)-1:0]       o_count
);

  localparam int PtrW   = $clog2(DEPTH);
  localparam int CountW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [PtrW-1:0]   r_wrPtr;
  logic [PtrW-1:0]   r_rdPtr;
  logic [CountW-1:0] r_count;

  // DEPTH is a power of two, so pointer overflow is the wrap.
  always_ff @(posedge i_clk) begin
    if (!i_rstN || i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (i_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rstN && !i_flush && i_push) r_mem[r_wrPtr] <= i_data;
  end

  assign o_head  = r_mem[r_rdPtr];
  assign o_count = r_count;

endmodule

// File: rtl/sc_regmir_pipe.sv
// Microinstruction register fed by a prefetch queue; decodes the current microword into fields.
module sc_regmir_pipe
  import sc_regmir_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_D,
  parameter int ALU_WIDTH      = ALU_WIDTH_D,
  parameter int COND_WIDTH     = COND_WIDTH_D,
  parameter int JMP_WIDTH      = JMP_WIDTH_D,
  parameter int DEPTH          = DEPTH_D
) (
  input  logic                                   SC_RegMIRPipe_CLOCK_50,
  input  logic                                   SC_RegMIRPipe_Reset_InLow,
  input  logic [mirWidth(REG_ADDR_WIDTH, ALU_WIDTH, COND_WIDTH, JMP_WIDTH)-1:0] SC_RegMIRPipe_DataBUS_In,
  input  logic                                   SC_RegMIRPipe_Valid_InHigh,
  output logic                                   SC_RegMIRPipe_Ready_OutHigh,
  input  logic                                   SC_RegMIRPipe_Advance_InHigh,
  input  logic                                   SC_RegMIRPipe_Flush_InHigh,
  output logic                                   SC_RegMIRPipe_Valid_OutHigh,
  output logic [$clog2(DEPTH+1)-1:0]             SC_RegMIRPipe_Count_Out,
  output logic [REG_ADDR_WIDTH-1:0]              SC_RegMIRPipe_A_Out,
  output logic                                   SC_RegMIRPipe_AMUX_Out,
  output logic [REG_ADDR_WIDTH-1:0]              SC_RegMIRPipe_B_Out,
  output logic                                   SC_RegMIRPipe_BMUX_Out,
  output logic [REG_ADDR_WIDTH-1:0]              SC_RegMIRPipe_C_Out,
  output logic                                   SC_RegMIRPipe_CMUX_Out,
  output logic                                   SC_RegMIRPipe_RD_Out,
  output logic                                   SC_RegMIRPipe_WR_Out,
  output logic [ALU_WIDTH-1:0]                   SC_RegMIRPipe_ALU_Out,
  output logic [COND_WIDTH-1:0]                  SC_RegMIRPipe_COND_Out,
  output logic [JMP_WIDTH-1:0]                   SC_RegMIRPipe_JMP_ADDR_Out
);

  localparam int BusWidth = mirWidth(REG_ADDR_WIDTH, ALU_WIDTH, COND_WIDTH, JMP_WIDTH);
  localparam int CountW   = $clog2(DEPTH + 1);
  localparam logic [BusWidth-1:0] DATA_MIR_INIT = '0;
  localparam logic [CountW-1:0]   FullCount     = CountW'(DEPTH);

  logic [BusWidth-1:0] r_mir;
  logic                r_valid;
  logic [BusWidth-1:0] w_head;
  logic [CountW-1:0]   w_count;
  logic                w_ready;
  logic                w_xfer;
  logic                w_load;
  logic                w_queued;
  logic                w_push;
  logic                w_pop;
  logic                w_rd;
  logic                w_wr;
  mirSrc_t             w_src;

  assign w_queued = (w_count != '0);
  assign w_ready  = !SC_RegMIRPipe_Flush_InHigh && (w_count < FullCount);
  assign w_xfer   = SC_RegMIRPipe_Valid_InHigh && w_ready;
  assign w_load   = SC_RegMIRPipe_Advance_InHigh || !r_valid;

  // Queue head wins over the live input so ordering is kept; an empty queue lets the input bypass.
  always_comb begin
    w_src = SRC_NOP;
    if (w_load && w_queued)    w_src = SRC_HEAD;
    else if (w_load && w_xfer) w_src = SRC_BYPASS;
  end

  assign w_pop  = !SC_RegMIRPipe_Flush_InHigh && (w_src == SRC_HEAD);
  assign w_push = w_xfer && (w_src != SRC_BYPASS);

  sc_regmir_fifo #(
    .WIDTH (BusWidth),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (SC_RegMIRPipe_CLOCK_50),
    .i_rstN  (SC_RegMIRPipe_Reset_InLow),
    .i_flush (SC_RegMIRPipe_Flush_InHigh),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (SC_RegMIRPipe_DataBUS_In),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge SC_RegMIRPipe_CLOCK_50) begin
    if (!SC_RegMIRPipe_Reset_InLow || SC_RegMIRPipe_Flush_InHigh) begin
      r_mir   <= DATA_MIR_INIT;
      r_valid <= 1'b0;
    end else if (w_load) begin
      case (w_src)
        SRC_HEAD: begin
          r_mir   <= w_head;
          r_valid <= 1'b1;
        end
        SRC_BYPASS: begin
          r_mir   <= SC_RegMIRPipe_DataBUS_In;
          r_valid <= 1'b1;
        end
        default: begin
          r_mir   <= DATA_MIR_INIT;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign {SC_RegMIRPipe_A_Out, SC_RegMIRPipe_AMUX_Out,
          SC_RegMIRPipe_B_Out, SC_RegMIRPipe_BMUX_Out,
          SC_RegMIRPipe_C_Out, SC_RegMIRPipe_CMUX_Out,
          w_rd, w_wr,
          SC_RegMIRPipe_ALU_Out, SC_RegMIRPipe_COND_Out,
          SC_RegMIRPipe_JMP_ADDR_Out} = r_mir;

  // Memory strobes must never fire from a stale or empty MIR.
  assign SC_RegMIRPipe_RD_Out = w_rd && r_valid;
  assign SC_RegMIRPipe_WR_Out = w_wr && r_valid;

  assign SC_RegMIRPipe_Ready_OutHigh = w_ready;
  assign SC_RegMIRPipe_Valid_OutHigh = r_valid;
  assign SC_RegMIRPipe_Count_Out     = w_count;

endmodule

// File: tb/tb_sc_regmir_pipe.sv
// Directed bench for sc_regmir_pipe: each task drives one scenario and checks against hand-built words.
module tb_sc_regmir_pipe;
  import sc_regmir_pkg::*;

  localparam int W = DATAWIDTH_BUS;

  logic         clk = 1'b0;
  logic         rstN = 1'b0;
  logic [W-1:0] dataIn = '0;
  logic         validIn = 1'b0;
  logic         advance = 1'b0;
  logic         flush = 1'b0;
  logic         ready;
  logic         validOut;
  logic [1:0]   count;
  logic [5:0]   oA, oB, oC;
  logic         oAmux, oBmux, oCmux, oRd, oWr;
  logic [3:0]   oAlu;
  logic [2:0]   oCond;
  logic [10:0]  oJmp;

  int total = 0;
  int bad = 0;
  logic [W+3:0] exp;

  always #5 clk = ~clk;

  sc_regmir_pipe dut (
    .SC_RegMIRPipe_CLOCK_50       (clk),
    .SC_RegMIRPipe_Reset_InLow    (rstN),
    .SC_RegMIRPipe_DataBUS_In     (dataIn),
    .SC_RegMIRPipe_Valid_InHigh   (validIn),
    .SC_RegMIRPipe_Ready_OutHigh  (ready),
    .SC_RegMIRPipe_Advance_InHigh (advance),
    .SC_RegMIRPipe_Flush_InHigh   (flush),
    .SC_RegMIRPipe_Valid_OutHigh  (validOut),
    .SC_RegMIRPipe_Count_Out      (count),
    .SC_RegMIRPipe_A_Out          (oA),
    .SC_RegMIRPipe_AMUX_Out       (oAmux),
    .SC_RegMIRPipe_B_Out          (oB),
    .SC_RegMIRPipe_BMUX_Out       (oBmux),
    .SC_RegMIRPipe_C_Out          (oC),
    .SC_RegMIRPipe_CMUX_Out       (oCmux),
    .SC_RegMIRPipe_RD_Out         (oRd),
    .SC_RegMIRPipe_WR_Out         (oWr),
    .SC_RegMIRPipe_ALU_Out        (oAlu),
    .SC_RegMIRPipe_COND_Out       (oCond),
    .SC_RegMIRPipe_JMP_ADDR_Out   (oJmp)
  );

  function automatic logic [W-1:0] mk(int a, int am, int b, int bm, int c, int cm,
                                      int rd, int wr, int alu, int cond, int jmp);
    return {a[5:0], am[0], b[5:0], bm[0], c[5:0], cm[0], rd[0], wr[0],
            alu[3:0], cond[2:0], jmp[10:0]};
  endfunction

  // Observed {valid, count, ready, fields} packed for one-shot comparison.
  function automatic logic [W+3:0] stat();
    return {validOut, count, ready, oA, oAmux, oB, oBmux, oC, oCmux, oRd, oWr, oAlu, oCond, oJmp};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rstN = 1'b0; validIn = 1'b0; advance = 1'b0; flush = 1'b0; dataIn = '0;
    step();
    step();
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    doReset();
    exp = {1'b0, 2'd0, 1'b1, {W{1'b0}}};
    total++; if (stat() !== exp) begin bad++; $display("FAIL reset got=%h want=%h", stat(), exp); end
    step();
    total++; if (stat() !== exp) begin bad++; $display("FAIL reset_idle got=%h want=%h", stat(), exp); end
  endtask

  task automatic test_bypass();
    logic [W-1:0] wb;
    doReset();
    wb = mk(5, 1, 9, 0, 12, 0, 1, 0, 3, 2, 'h1A5);
    dataIn = wb; validIn = 1'b1; advance = 1'b0;
    step();
    validIn = 1'b0;
    exp = {1'b1, 2'd0, 1'b1, wb};
    total++; if (stat() !== exp) begin bad++; $display("FAIL bypass got=%h want=%h", stat(), exp); end
    total++; if (oA !== 6'd5 || oC !== 6'd12 || oRd !== 1'b1 || oJmp !== 11'h1A5)
      begin bad++; $display("FAIL bypass_fields got=%0d/%0d/%0d/%h want=5/12/1/1a5", oA, oC, oRd, oJmp); end
  endtask

  task automatic test_fill_full();
    logic [W-1:0] w1, w2, w3, w4;
    doReset();
    w1 = mk(1, 0, 2, 1, 3, 0, 1, 0, 1, 1, 'h101);
    w2 = mk(4, 1, 5, 0, 6, 1, 0, 1, 2, 3, 'h202);
    w3 = mk(7, 0, 8, 1, 9, 0, 1, 1, 4, 5, 'h303);
    w4 = mk(10, 1, 11, 0, 13, 1, 0, 0, 8, 7, 'h404);
    advance = 1'b0; validIn = 1'b1; dataIn = w1;
    step();
    exp = {1'b1, 2'd0, 1'b1, w1};
    total++; if (stat() !== exp) begin bad++; $display("FAIL fill_w1 got=%h want=%h", stat(), exp); end
    dataIn = w2;
    step();
    exp = {1'b1, 2'd1, 1'b1, w1};
    total++; if (stat() !== exp) begin bad++; $display("FAIL fill_w2 got=%h want=%h", stat(), exp); end
    dataIn = w3;
    step();
    exp = {1'b1, 2'd2, 1'b0, w1};
    total++; if (stat() !== exp) begin bad++; $display("FAIL fill_full got=%h want=%h", stat(), exp); end
    dataIn = w4;
    step();
    total++; if (stat() !== exp) begin bad++; $display("FAIL fill_held got=%h want=%h", stat(), exp); end
    advance = 1'b1;
    step();
    exp = {1'b1, 2'd1, 1'b1, w2};
    total++; if (stat() !== exp) begin bad++; $display("FAIL fill_adv got=%h want=%h", stat(), exp); end
    advance = 1'b0;
    step();
    validIn = 1'b0;
    exp = {1'b1, 2'd2, 1'b0, w2};
    total++; if (stat() !== exp) begin bad++; $display("FAIL fill_w4push got=%h want=%h", stat(), exp); end
    advance = 1'b1;
    step();
    exp = {1'b1, 2'd1, 1'b1, w3};
    total++; if (stat() !== exp) begin bad++; $display("FAIL order_w3 got=%h want=%h", stat(), exp); end
    step();
    exp = {1'b1, 2'd0, 1'b1, w4};
    total++; if (stat() !== exp) begin bad++; $display("FAIL order_w4 got=%h want=%h", stat(), exp); end
    step();
    exp = {1'b0, 2'd0, 1'b1, {W{1'b0}}};
    total++; if (stat() !== exp) begin bad++; $display("FAIL empty_adv got=%h want=%h", stat(), exp); end
    advance = 1'b0;
  endtask

  task automatic test_flush();
    logic [W-1:0] w5;
    doReset();
    validIn = 1'b1;
    dataIn = mk(1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1);
    step();
    dataIn = mk(2, 0, 2, 0, 2, 0, 1, 1, 2, 2, 2);
    step();
    dataIn = mk(3, 1, 3, 1, 3, 1, 1, 1, 3, 3, 3);
    step();
    total++; if (count !== 2'd2) begin bad++; $display("FAIL flush_prefull got=%0d want=2", count); end
    w5 = mk(63, 1, 63, 1, 63, 1, 1, 1, 15, 7, 'h7FF);
    dataIn = w5; flush = 1'b1;
    #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b want=0", ready); end
    step();
    exp = {1'b0, 2'd0, 1'b0, {W{1'b0}}};
    total++; if (stat() !== exp) begin bad++; $display("FAIL flush got=%h want=%h", stat(), exp); end
    total++; if (oRd !== 1'b0 || oWr !== 1'b0) begin bad++; $display("FAIL flush_rdwr got=%b%b want=00", oRd, oWr); end
    flush = 1'b0; validIn = 1'b0;
    #1;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL flush_ready_after got=%b want=1", ready); end
    step();
    exp = {1'b0, 2'd0, 1'b1, {W{1'b0}}};
    total++; if (stat() !== exp) begin bad++; $display("FAIL flush_dropped got=%h want=%h", stat(), exp); end
  endtask

  task automatic test_drain_wrap();
    logic [W-1:0] d [5];
    doReset();
    for (int i = 0; i < 5; i++) d[i] = mk(i + 20, i % 2, i + 30, 1, i + 40, 0, 1, i % 2, i + 2, i, 'h500 + i);
    validIn = 1'b1; advance = 1'b0; dataIn = d[0];
    step();
    exp = {1'b1, 2'd0, 1'b1, d[0]};
    total++; if (stat() !== exp) begin bad++; $display("FAIL drain_d0 got=%h want=%h", stat(), exp); end
    dataIn = d[1];
    step();
    exp = {1'b1, 2'd1, 1'b1, d[0]};
    total++; if (stat() !== exp) begin bad++; $display("FAIL drain_q1 got=%h want=%h", stat(), exp); end
    advance = 1'b1;
    for (int i = 2; i < 5; i++) begin
      dataIn = d[i];
      step();
      exp = {1'b1, 2'd1, 1'b1, d[i-1]};
      total++; if (stat() !== exp) begin bad++; $display("FAIL drain_d%0d got=%h want=%h", i - 1, stat(), exp); end
    end
    validIn = 1'b0;
    step();
    exp = {1'b1, 2'd0, 1'b1, d[4]};
    total++; if (stat() !== exp) begin bad++; $display("FAIL drain_d4 got=%h want=%h", stat(), exp); end
    step();
    exp = {1'b0, 2'd0, 1'b1, {W{1'b0}}};
    total++; if (stat() !== exp) begin bad++; $display("FAIL drain_end got=%h want=%h", stat(), exp); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e;
    advance = 1'b1; validIn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e = mk(i + 1, 1, i + 2, 0, i + 3, 1, 0, 1, 9 - i, 6, 'h0F0 + i);
      dataIn = e;
      step();
      exp = {1'b1, 2'd0, 1'b1, e};
      total++; if (stat() !== exp) begin bad++; $display("FAIL b2b_%0d got=%h want=%h", i, stat(), exp); end
    end
    validIn = 1'b0; advance = 1'b0;
  endtask

  task automatic test_reset_midstream();
    logic [W-1:0] w1;
    doReset();
    w1 = mk(33, 1, 34, 0, 35, 1, 1, 1, 5, 4, 'h2AA);
    validIn = 1'b1; dataIn = w1;
    step();
    dataIn = mk(36, 0, 37, 1, 38, 0, 1, 0, 6, 1, 'h155);
    step();
    exp = {1'b1, 2'd1, 1'b1, w1};
    total++; if (stat() !== exp) begin bad++; $display("FAIL mid_pre got=%h want=%h", stat(), exp); end
    rstN = 1'b0;
    dataIn = mk(39, 1, 40, 1, 41, 1, 1, 1, 7, 2, 'h333);
    step();
    exp = {1'b0, 2'd0, 1'b1, {W{1'b0}}};
    total++; if (stat() !== exp) begin bad++; $display("FAIL mid_reset got=%h want=%h", stat(), exp); end
    rstN = 1'b1; validIn = 1'b0;
    step();
    total++; if (stat() !== exp) begin bad++; $display("FAIL mid_after got=%h want=%h", stat(), exp); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_fill_full();
    test_flush();
    test_drain_wrap();
    test_back_to_back();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
